led_panel_fb_ctrl: RTL
======================

# led_panel_fb_ctrl

Double-buffered frame-store controller for the 32x16 LED panel. It parses command bytes from the UART receiver and writes them into a back buffer, while the scan engine reads the front buffer. Buffer swaps and colour changes take effect only at frame boundaries, so the display never tears mid-scan. It sits between `uart_rx` and the panel scan FSM, replacing the fixed reset-time frame buffer.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum idle `clk` cycles between bytes of a multi-byte command before the command is aborted.
- `RGB_RESET`, default 3'b101: colour loaded at reset.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx_dv`  in  1  one-cycle strobe; `rx_byte` is valid.
- `rx_byte`  in  8  received command/data byte.
- `frame_done`  in  1  one-cycle pulse from the scanner when row count wraps 3->0.
- `rd_col`  in  4  scanner read address (frame column 0..15).
- `rd_data`  out  8  front-buffer column; bit n = panel row n.
- `rgb`  out  3  active colour {r,g,b}.
- `busy`  out  1  high while in CLEAR.
- `swap_pending`  out  1  swap requested, not yet applied.
- `err`  out  1  one-cycle pulse on a protocol error.

## Operation
- Storage: two banks, each 16 x 8 bits; `bank_sel` selects the front bank; the back bank is `~bank_sel`.
- Opcodes (first byte, state IDLE):
  - 0x80-0x87: `rgb_pend <= byte[2:0]`, `rgb_pend_v <= 1`.
  - 0x90: enter CLEAR.
  - 0xA0-0xAF: `wr_col <= byte[3:0]`; enter COL_DATA.
  - 0xB0: `wr_col <= 0`; enter FRAME_DATA.
  - 0xC0: `swap_pending <= 1` (no-op if already set).
  - Any other byte: `err` pulse; stay in IDLE.
- COL_DATA: the next byte is written to `back[wr_col]`; return to IDLE.
- FRAME_DATA: each byte is written to `back[wr_col]` and `wr_col` increments. After column 15 is written, return to IDLE (wr_col wraps to 0).
- CLEAR: zeroes one back-bank column per cycle, columns 0..15 (16 cycles), then returns to IDLE. Any `rx_dv` during CLEAR is dropped with an `err` pulse.
- Timeout: in COL_DATA or FRAME_DATA, the idle counter resets on every `rx_dv`. When it reaches `TIMEOUT_CYCLES`-1, the FSM returns to IDLE with an `err` pulse. Partial columns already written stay written.
- On `frame_done`:
  - If `swap_pending`, toggle `bank_sel` and clear `swap_pending`.
  - If `rgb_pend_v`, `rgb <= rgb_pend` and clear `rgb_pend_v`.
- Simultaneous events:
  - A back-bank write in the same cycle as a swap uses the pre-swap `bank_sel`, so the data lands in the new front bank.
  - 0xC0 accepted on the same cycle as `frame_done`: `swap_pending` is set and the swap applies at the next `frame_done`.
  - 0x8x on the same cycle as `frame_done`: the new value goes pending and applies at the next `frame_done`.
- Reset values:
  - Both banks all-zero; `bank_sel`=0; state IDLE.
  - `rgb`=`RGB_RESET`; `rgb_pend_v`=0.
  - `swap_pending`=0; `busy`=0; `err`=0; `rd_data`=0.
- Reset asserted mid-command aborts the command with no `err` pulse.

## Timing
- `rd_data` is registered: it equals `front[rd_col]` sampled 1 cycle earlier. The scanner presents the address one state ahead.
- A byte accepted on cycle N is visible in the back bank at N+1.
- Swap and colour changes are visible on `rd_data`/`rgb` from the cycle after `frame_done` (the `rd_data` swap is seen 2 cycles after `frame_done` for an unchanged `rd_col`).
- `busy` is high for exactly 16 cycles per clear, starting the cycle after 0x90 is accepted.
- `err` is a single-cycle pulse and is never held.

## Structure
- Package `led_panel_pkg`:
  - opcode constants `OP_RGB`, `OP_CLR`, `OP_COL`, `OP_FRAME`, `OP_SWAP`
  - state encodings IDLE / COL_DATA / FRAME_DATA / CLEAR
  - `FB_COLS`=16, `FB_ROWS`=8
- Sub-module `led_panel_fb_bank`: 16x8 register array with synchronous reset-to-zero, one write port (en, addr, data) and one registered read port. Instantiated twice, with the read mux on `bank_sel`.

## Test plan
- Reset, then `rd_col`=0..15 -> `rd_data`=0x00 everywhere; `rgb`=3'b101; `swap_pending`=0.
- Bytes 0xA3, 0x5A, then 0xC0, then `frame_done` -> `swap_pending` falls; `rd_data` at `rd_col`=3 is 0x5A and 0x00 elsewhere.
- 0xB0 plus 16 bytes 0x00..0x0F, 0xC0, `frame_done` -> `rd_data`[k]=k; then 0x90 -> `busy` high for 16 cycles; `rx_dv` during CLEAR -> `err` pulse, byte ignored.
- 0x82 with no `frame_done` -> `rgb` stays 101; after `frame_done` -> `rgb`=010. Sending 0x84 on the same cycle as `frame_done` -> applied only at the following `frame_done`.
- 0xA7 then silence for `TIMEOUT_CYCLES` -> `err` pulse, IDLE; next byte 0x55 -> `err` pulse (invalid opcode), bank unchanged.
- 0xB0 plus 5 bytes, then `reset` -> all outputs return to reset values; subsequent 0xA0, 0xFF works normally.

Source files
------------

// File: rtl/led_panel_pkg.sv
// Shared definitions for the LED panel frame-store controller.
// Holds the frame-buffer geometry, command opcodes, FSM state encoding
// and a byte-to-opcode classifier used by the command parser.
package led_panel_pkg;

    localparam int unsigned FB_COLS = 16;
    localparam int unsigned FB_ROWS = 8;
    localparam int unsigned COL_W   = $clog2(FB_COLS);

    typedef logic [COL_W-1:0]   col_t;
    typedef logic [FB_ROWS-1:0] col_data_t;

    // Opcode base values; OP_RGB and OP_COL carry an operand in the low bits.
    localparam logic [7:0] OP_RGB   = 8'h80;
    localparam logic [7:0] OP_CLR   = 8'h90;
    localparam logic [7:0] OP_COL   = 8'hA0;
    localparam logic [7:0] OP_FRAME = 8'hB0;
    localparam logic [7:0] OP_SWAP  = 8'hC0;

    typedef enum logic [1:0] {
        StIdle,
        StColData,
        StFrameData,
        StClear
    } state_e;

    typedef enum logic [2:0] {
        OpRgb,
        OpClr,
        OpCol,
        OpFrame,
        OpSwap,
        OpBad
    } op_e;

    // Classify a first-of-command byte.
    function automatic op_e decode_op(input logic [7:0] b);
        if (b[7:3] == OP_RGB[7:3]) begin
            return OpRgb;
        end else if (b == OP_CLR) begin
            return OpClr;
        end else if (b[7:4] == OP_COL[7:4]) begin
            return OpCol;
        end else if (b == OP_FRAME) begin
            return OpFrame;
        end else if (b == OP_SWAP) begin
            return OpSwap;
        end
        return OpBad;
    endfunction

endpackage

// File: rtl/led_panel_fb_bank.sv
// One frame-buffer bank: FB_COLS x FB_ROWS register array.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset, clears every column
//   wr_en_i    write strobe
//   wr_addr_i  write column
//   wr_data_i  write data (bit n = panel row n)
//   rd_addr_i  read column
//   rd_data_o  registered read data (contents before any same-cycle write)
module led_panel_fb_bank
    import led_panel_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      wr_en_i,
    input  col_t      wr_addr_i,
    input  col_data_t wr_data_i,
    input  col_t      rd_addr_i,
    output col_data_t rd_data_o
);

    col_data_t mem_q [FB_COLS];
    col_data_t rd_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FB_COLS; i++) begin
                mem_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/led_panel_fb_ctrl.sv
// Double-buffered frame-store controller for the 32x16 LED panel.
// Parses UART command bytes, writes the back bank, and lets the scanner read
// the front bank. Swaps and colour changes are applied only on frame_done.
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset
//   rx_dv         one-cycle strobe, rx_byte valid
//   rx_byte       command/data byte
//   frame_done    one-cycle frame-boundary pulse from the scanner
//   rd_col        scanner read column
//   rd_data       registered front-bank column
//   rgb           active colour {r,g,b}
//   busy          high while clearing the back bank
//   swap_pending  swap requested, not yet applied
//   err           one-cycle protocol error pulse
module led_panel_fb_ctrl
    import led_panel_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [2:0]  RGB_RESET      = 3'b101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    input  logic       frame_done,
    input  logic [3:0] rd_col,
    output logic [7:0] rd_data,
    output logic [2:0] rgb,
    output logic       busy,
    output logic       swap_pending,
    output logic       err
);

    localparam int unsigned CntW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    state_e          state_q;
    col_t            wr_col_q;
    col_t            clr_col_q;
    logic [CntW-1:0] idle_cnt_q;
    logic            bank_sel_q;
    logic            bank_sel_rd_q;
    logic            swap_pending_q;
    logic [2:0]      rgb_q;
    logic [2:0]      rgb_pend_q;
    logic            rgb_pend_v_q;
    logic            err_q;

    op_e       op;
    logic      wr_en;
    col_t      wr_addr;
    col_data_t wr_data;
    col_data_t rd_data0;
    col_data_t rd_data1;

    assign op = decode_op(rx_byte);

    // Back-bank write port; bank_sel_q is the pre-swap value on a frame_done cycle.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wr_col_q;
        wr_data = rx_byte;
        unique case (state_q)
            StColData, StFrameData: wr_en = rx_dv;
            StClear: begin
                wr_en   = 1'b1;
                wr_addr = clr_col_q;
                wr_data = '0;
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            wr_col_q       <= '0;
            clr_col_q      <= '0;
            idle_cnt_q     <= '0;
            bank_sel_q     <= 1'b0;
            bank_sel_rd_q  <= 1'b0;
            swap_pending_q <= 1'b0;
            rgb_q          <= RGB_RESET;
            rgb_pend_q     <= RGB_RESET;
            rgb_pend_v_q   <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            err_q         <= 1'b0;
            // Delayed select lines the bank mux up with the registered bank reads.
            bank_sel_rd_q <= bank_sel_q;

            // Frame-boundary updates first, so a same-cycle request below overrides
            // the clear and is deferred to the following boundary.
            if (frame_done) begin
                if (swap_pending_q) begin
                    bank_sel_q     <= ~bank_sel_q;
                    swap_pending_q <= 1'b0;
                end
                if (rgb_pend_v_q) begin
                    rgb_q        <= rgb_pend_q;
                    rgb_pend_v_q <= 1'b0;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (rx_dv) begin
                        idle_cnt_q <= '0;
                        unique case (op)
                            OpRgb: begin
                                rgb_pend_q   <= rx_byte[2:0];
                                rgb_pend_v_q <= 1'b1;
                            end
                            OpClr: begin
                                clr_col_q <= '0;
                                state_q   <= StClear;
                            end
                            OpCol: begin
                                wr_col_q <= rx_byte[3:0];
                                state_q  <= StColData;
                            end
                            OpFrame: begin
                                wr_col_q <= '0;
                                state_q  <= StFrameData;
                            end
                            OpSwap:  swap_pending_q <= 1'b1;
                            default: err_q          <= 1'b1;
                        endcase
                    end
                end
                StColData, StFrameData: begin
                    if (rx_dv) begin
                        idle_cnt_q <= '0;
                        if (state_q == StFrameData) begin
                            wr_col_q <= wr_col_q + 4'd1;
                            if (wr_col_q == col_t'(FB_COLS - 1)) begin
                                state_q <= StIdle;
                            end
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (idle_cnt_q == CntMax) begin
                        // Abandon the command; columns already written are kept.
                        state_q <= StIdle;
                        err_q   <= 1'b1;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                StClear: begin
                    if (rx_dv) begin
                        err_q <= 1'b1;
                    end
                    clr_col_q <= clr_col_q + 4'd1;
                    if (clr_col_q == col_t'(FB_COLS - 1)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    led_panel_fb_bank u_bank0 (
        .clk_i     (clk),
        .rst_i     (reset),
        .wr_en_i   (wr_en & bank_sel_q),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_col),
        .rd_data_o (rd_data0)
    );

    led_panel_fb_bank u_bank1 (
        .clk_i     (clk),
        .rst_i     (reset),
        .wr_en_i   (wr_en & ~bank_sel_q),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_col),
        .rd_data_o (rd_data1)
    );

    assign rd_data      = bank_sel_rd_q ? rd_data1 : rd_data0;
    assign rgb          = rgb_q;
    assign busy         = (state_q == StClear);
    assign swap_pending = swap_pending_q;
    assign err          = err_q;

endmodule
